// File: rtl/fpu_float_square_pkg.sv
// Package for the iterative single-precision squaring unit.
//
// Holds the float field/condition/result types shared with the FPU rounding
// stage, the FSM state enum, the per-operation working record, and the three
// pure functions the datapath is built from:
//   fpu_float_square_decode    - operand capture at accept time
//   fpu_float_square_step      - one BITS_PER_CYCLE slice of shift-add multiply
//   fpu_float_square_normalize - 48-bit product to unrounded fpu_result_t
package fpu_float_square_pkg;

  localparam int MANT_BITS = 24;  // significand width including hidden one
  localparam int PROD_BITS = 48;
  localparam int EXP_BIAS  = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fpu_float_fields_t;

  typedef struct packed {
    logic norm;
    logic nan;
    logic inf;
    logic zero;
  } fpu_float_conditions_t;

  typedef enum logic [2:0] {
    RND_NEAREST_EVEN = 3'd0,
    RND_TO_ZERO      = 3'd1,
    RND_DOWN         = 3'd2,
    RND_UP           = 3'd3,
    RND_NEAREST_MAX  = 3'd4
  } fpu_round_mode_t;

  typedef struct packed {
    logic            sign;
    logic [7:0]      exponent;
    logic [23:0]     mantissa;
    logic [2:0]      guard;
    logic            nan;
    logic            inf;
    logic            zero;
    logic            valid;
    fpu_round_mode_t mode;
  } fpu_result_t;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_MUL  = 2'd1,
    SQ_NORM = 2'd2,
    SQ_DONE = 2'd3
  } fpu_square_state_t;

  // Denormal inputs are folded into zero here since squares flush to zero.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fpu_square_flags_t;

  typedef struct packed {
    logic [47:0]       acc;
    logic [23:0]       multiplicand;
    logic [23:0]       multiplier;
    logic [4:0]        count;
    logic [9:0]        exponent;      // unbiased, two's complement
    fpu_square_flags_t flags;
    fpu_round_mode_t   mode;
  } fpu_square_partial_t;

  function automatic fpu_square_partial_t fpu_float_square_decode(
    input fpu_float_fields_t     number,
    input fpu_float_conditions_t cond,
    input fpu_round_mode_t       mode
  );
    fpu_square_partial_t p;
    p              = '0;
    p.multiplicand = {1'b1, number.mantissa};
    p.multiplier   = {1'b1, number.mantissa};
    p.exponent     = {2'b00, number.exponent} - 10'(EXP_BIAS);
    p.flags.nan    = cond.nan;
    p.flags.inf    = cond.inf;
    p.flags.zero   = cond.zero | ~cond.norm;
    p.mode         = mode;
    return p;
  endfunction

  // Consumes the low 'bits' multiplier bits. count tracks the weight of bit 0
  // of the (already shifted) multiplier register.
  function automatic fpu_square_partial_t fpu_float_square_step(
    input fpu_square_partial_t p,
    input int                  bits
  );
    fpu_square_partial_t n;
    n = p;
    for (int i = 0; i < MANT_BITS; i++) begin
      if (i < bits && p.multiplier[i]) begin
        n.acc = n.acc + ({24'd0, p.multiplicand} << (int'(p.count) + i));
      end
    end
    n.multiplier = p.multiplier >> bits;
    n.count      = p.count + 5'(bits);
    return n;
  endfunction

  function automatic fpu_result_t fpu_float_square_normalize(
    input fpu_square_partial_t p
  );
    fpu_result_t       r;
    logic signed [9:0] e;
    logic signed [9:0] e2;
    logic signed [9:0] biased;
    r      = '0;
    r.mode = p.mode;
    e      = $signed(p.exponent);
    e2     = '0;
    biased = '0;
    if (p.flags.nan) begin
      r.nan = 1'b1;
    end else if (p.flags.inf) begin
      r.inf = 1'b1;
    end else if (p.flags.zero) begin
      r.zero = 1'b1;
    end else begin
      // Product of two [1,2) significands lies in [1,4): at most one bit of
      // normalisation shift, folded into the exponent as the +1.
      if (p.acc[47]) begin
        r.mantissa = p.acc[47:24];
        r.guard    = {p.acc[23:22], |p.acc[21:0]};
        e2         = (e <<< 1) + 10'sd1;
      end else begin
        r.mantissa = p.acc[46:23];
        r.guard    = {p.acc[22:21], |p.acc[20:0]};
        e2         = e <<< 1;
      end
      biased = e2 + 10'sd127;
      // Out-of-range results are reported as pure flags with zeroed fields.
      if (biased > 10'sd254) begin
        r.inf      = 1'b1;
        r.mantissa = '0;
        r.guard    = '0;
      end else if (biased < 10'sd1) begin
        r.zero     = 1'b1;
        r.mantissa = '0;
        r.guard    = '0;
      end else begin
        r.exponent = biased[7:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_float_square.sv
// Iterative single-precision squaring unit (x*x) producing an unrounded
// fpu_result_t for the shared FPU rounding stage.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - operand handshake; in_ready is high only when idle
//   in_number       - operand fields {sign, exponent, mantissa}
//   in_conditions   - {norm, nan, inf, zero} classification of in_number
//   in_mode         - round mode, passed through to out_result.mode
//   out_valid/ready - result handshake; out_result holds until accepted
//   out_result      - {sign, exponent, mantissa[23:0], guard[2:0], flags,
//                      valid, mode}
//
// Parameter BITS_PER_CYCLE: multiplier bits per iteration; must divide 24.
// Optional macro FPU_SQUARE_SPECIAL_BYPASS_EN: nan/inf/zero/denormal operands
// skip the multiply and complete one cycle after accept. Without it every
// operand takes the full 24/BITS_PER_CYCLE + 2 cycle latency.
//
// FSM:
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   MUL   | shift-add iterations, BITS_PER_CYCLE multiplier bits per cycle
//   NORM  | normalise product, compute exponent, apply flags
//   DONE  | out_valid high, result held until out_ready
module fpu_float_square
  import fpu_float_square_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  fpu_float_fields_t     in_number,
  input  fpu_float_conditions_t in_conditions,
  input  fpu_round_mode_t       in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output fpu_result_t           out_result
);

  // count value at the start of the final MUL iteration
  localparam logic [4:0] LAST_COUNT = 5'(MANT_BITS - BITS_PER_CYCLE);

  fpu_square_state_t   state;
  fpu_square_state_t   state_next;
  fpu_square_partial_t part;
  fpu_square_partial_t decoded;
  fpu_result_t         result_q;

  assign decoded = fpu_float_square_decode(in_number, in_conditions, in_mode);

`ifdef FPU_SQUARE_SPECIAL_BYPASS_EN
  logic special;
  assign special = |decoded.flags;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SQ_IDLE: begin
        if (in_valid) begin
`ifdef FPU_SQUARE_SPECIAL_BYPASS_EN
          state_next = special ? SQ_DONE : SQ_MUL;
`else
          state_next = SQ_MUL;
`endif
        end
      end
      SQ_MUL:  if (part.count == LAST_COUNT) state_next = SQ_NORM;
      SQ_NORM: state_next = SQ_DONE;
      SQ_DONE: if (out_ready) state_next = SQ_IDLE;
      default: state_next = SQ_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == SQ_IDLE);
    out_valid = (state == SQ_DONE);
  end

  always_comb begin
    out_result       = result_q;
    out_result.valid = out_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      part     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        SQ_IDLE: begin
          if (in_valid) begin
            part <= decoded;
`ifdef FPU_SQUARE_SPECIAL_BYPASS_EN
            // normalize() resolves flagged operands without looking at acc
            if (special) result_q <= fpu_float_square_normalize(decoded);
`endif
          end
        end
        SQ_MUL:  part     <= fpu_float_square_step(part, BITS_PER_CYCLE);
        SQ_NORM: result_q <= fpu_float_square_normalize(part);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_float_square.sv
module tb_fpu_float_square;
  import fpu_float_square_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [2:0]            in_valid;
  logic [2:0]            in_ready;
  logic [2:0]            out_valid;
  logic [2:0]            out_ready;
  fpu_float_fields_t     in_number     [3];
  fpu_float_conditions_t in_conditions [3];
  fpu_round_mode_t       in_mode       [3];
  fpu_result_t           out_result    [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 4 : 24);
    fpu_float_square #(.BITS_PER_CYCLE(BPC)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .in_number     (in_number[g]),
      .in_conditions (in_conditions[g]),
      .in_mode       (in_mode[g]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready[g]),
      .out_result    (out_result[g])
    );
  end

  function automatic int bpc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 24);
  endfunction

  function automatic fpu_float_conditions_t cond_of(input logic [31:0] num);
    fpu_float_conditions_t c;
    int ex;
    ex     = int'(num[30:23]);
    c.norm = (ex != 0) && (ex != 255);
    c.nan  = (ex == 255) && (num[22:0] != 0);
    c.inf  = (ex == 255) && (num[22:0] == 0);
    c.zero = (ex == 0) && (num[22:0] == 0);
    return c;
  endfunction

  function automatic int exp_lat(input int d, input logic [31:0] num);
    int ex;
    ex = int'(num[30:23]);
`ifdef FPU_SQUARE_SPECIAL_BYPASS_EN
    if (ex == 0 || ex == 255) return 1;
`endif
    if (ex < 0) return 0;
    return 24 / bpc_of(d) + 2;
  endfunction

  // Reference: real square of the significand, then scale and flag by value.
  function automatic fpu_result_t ref_square(input logic [31:0] num,
                                             input logic [2:0]  mode);
    fpu_result_t r;
    logic [63:0] m, p, rem;
    int ex, shift, e2, biased;
    r       = '0;
    r.valid = 1'b1;
    r.mode  = fpu_round_mode_t'(mode);
    ex      = int'(num[30:23]);
    if (ex == 255 && num[22:0] != 0) r.nan = 1'b1;
    else if (ex == 255)              r.inf = 1'b1;
    else if (ex == 0)                r.zero = 1'b1;
    else begin
      m = {40'd0, 1'b1, num[22:0]};
      p = m * m;
      if (p >= (64'd1 << 47)) begin
        shift = 24;
        e2    = 2 * (ex - 127) + 1;
      end else begin
        shift = 23;
        e2    = 2 * (ex - 127);
      end
      biased = e2 + 127;
      if (biased > 254)    r.inf = 1'b1;
      else if (biased < 1) r.zero = 1'b1;
      else begin
        rem          = p & ((64'd1 << shift) - 64'd1);
        r.exponent   = 8'(biased);
        r.mantissa   = 24'(p >> shift);
        r.guard[2:1] = 2'((rem >> (shift - 2)) & 64'd3);
        r.guard[0]   = (rem & ((64'd1 << (shift - 2)) - 64'd1)) != 64'd0;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input int d, input logic [31:0] num,
                            input logic [2:0] mode);
    in_number[d]     = fpu_float_fields_t'(num);
    in_conditions[d] = cond_of(num);
    in_mode[d]       = fpu_round_mode_t'(mode);
  endtask

  task automatic start_op(input int d, input logic [31:0] num,
                          input logic [2:0] mode);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 64'(in_ready[d]), 64'd1);
    set_inputs(d, num, mode);
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid[d] && lat < 200);
  endtask

  task automatic finish_op(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
  endtask

  task automatic run_check(input int d, input logic [31:0] num,
                           input logic [2:0] mode, input string tag);
    int lat;
    start_op(d, num, mode);
    wait_done(d, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(d, num)));
    check({tag, "_res"}, 64'(out_result[d]), 64'(ref_square(num, mode)));
    finish_op(d);
  endtask

  initial begin
    fpu_result_t snap;
    int          lat;
    logic [31:0] num;
    logic [2:0]  mode;
    int          n_rand;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) set_inputs(i, 32'd0, 3'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready[0]), 64'd1);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_out_result", 64'(out_result[0]), 64'd0);
    rst = 1'b0;

    // directed vectors
    start_op(0, 32'h40400000, 3'd0);
    wait_done(0, lat);
    check("three_lat", 64'(lat), 64'd26);
    check("three_exp", 64'(out_result[0].exponent), 64'd130);
    check("three_mant", 64'(out_result[0].mantissa), 64'h900000);
    check("three_res", 64'(out_result[0]), 64'(ref_square(32'h40400000, 3'd0)));
    finish_op(0);
    run_check(0, 32'hC0000000, 3'd1, "neg_two");
    run_check(0, 32'h3F800001, 3'd2, "one_ulp");
    run_check(0, 32'h7F000000, 3'd3, "overflow");
    run_check(0, 32'h1F800000, 3'd4, "underflow");
    run_check(0, 32'h00000001, 3'd0, "denormal");
    run_check(0, 32'h00000000, 3'd0, "zero");
    run_check(0, 32'h7F800000, 3'd1, "inf_in");
    run_check(0, 32'h7FC00000, 3'd2, "nan_in");
    run_check(2, 32'h7FC00000, 3'd3, "nan_in_b24");

    // output stall: result held, unit busy, then back-to-back accept
    start_op(0, 32'h40400000, 3'd3);
    wait_done(0, lat);
    check("stall_lat", 64'(lat), 64'd26);
    snap = out_result[0];
    check("stall_res", 64'(snap), 64'(ref_square(32'h40400000, 3'd3)));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", 64'(out_result[0]), 64'(snap));
      check("stall_busy", 64'(in_ready[0]), 64'd0);
    end
    set_inputs(0, 32'h3F800001, 3'd1);
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    @(negedge clk);
    check("hs_ready", 64'(in_ready[0]), 64'd1);
    check("hs_out_valid", 64'(out_valid[0]), 64'd0);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    wait_done(0, lat);
    check("b2b_lat", 64'(lat), 64'd26);
    check("b2b_res", 64'(out_result[0]), 64'(ref_square(32'h3F800001, 3'd1)));
    finish_op(0);

    // reset in the middle of MUL
    start_op(0, 32'h40400000, 3'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid[0]), 64'd0);
    check("abort_in_ready", 64'(in_ready[0]), 64'd1);
    run_check(0, 32'hC0000000, 3'd2, "post_abort");

    // random normals across the three slice widths
    for (int d = 0; d < 3; d++) begin
      n_rand = (d == 0) ? 600 : 1000;
      for (int k = 0; k < n_rand; k++) begin
        num  = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        mode = 3'($urandom_range(0, 4));
        run_check(d, num, mode, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
